// File: rtl/buf_collect_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// buf_collect_arbiter_pkg
// Shared multicore definitions used by the result-collection arbiter:
//   - arb_state_t : two-state collector FSM encoding (SCAN / CAPTURE)
//   - CORE_ID_W   : width of a core index carried with each result
//   - VAL_W       : width of one core result word
//   - ENTRY_W     : width of one result-queue entry {core_id, val_1, val_2}
//   - pack_entry  : builds a queue entry from its fields
// ---------------------------------------------------------------------------
package buf_collect_arbiter_pkg;

  localparam int CORE_ID_W = 5;
  localparam int VAL_W     = 32;
  localparam int ENTRY_W   = CORE_ID_W + 2 * VAL_W;

  typedef enum logic {
    ST_SCAN    = 1'b0,
    ST_CAPTURE = 1'b1
  } arb_state_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [CORE_ID_W-1:0] core_id,
    input logic [VAL_W-1:0]     val_1,
    input logic [VAL_W-1:0]     val_2
  );
    return {core_id, val_1, val_2};
  endfunction

endpackage

// File: rtl/buf_collect_arbiter_result_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
// Small synchronous FIFO holding captured core results until the parent
// core accepts them.
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   push, din      : write request and data (ignored when full with no pop)
//   pop            : read request (ignored when empty)
//   dout           : head entry (undefined contents while empty)
//   full, empty    : occupancy flags derived from the registered count
//   count          : number of valid entries (0..DEPTH)
// ---------------------------------------------------------------------------
module result_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full queue is only legal if the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally on overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/buf_collect_arbiter.sv
// ---------------------------------------------------------------------------
// buf_collect_arbiter
// Round-robin collector that scans child cores for ready results, captures
// each core at most once per epoch, acknowledges it, and queues the result
// for the parent core.
// Ports:
//   Clk, Reset          : clock and synchronous active-high reset
//   buf_flag            : per-core "result ready" flags
//   buf_val_1_flat/_2   : per-core result words, core i at [32i+31:32i]
//   clear_epoch         : pulse that forgets which cores were collected
//   buf_ack             : one-hot ack pulse to the captured core
//   out_valid/out_ready : result-queue head handshake
//   out_core_id/val_1/2 : head entry fields (zero while the queue is empty)
//   all_done            : every core collected in the current epoch
//   busy                : capture in progress or results still queued
// ---------------------------------------------------------------------------
module buf_collect_arbiter
  import buf_collect_arbiter_pkg::*;
#(
  parameter int NUM_CORES  = 31,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_CORES-1:0]       buf_flag,
  input  logic [VAL_W*NUM_CORES-1:0] buf_val_1_flat,
  input  logic [VAL_W*NUM_CORES-1:0] buf_val_2_flat,
  input  logic                       clear_epoch,
  output logic [NUM_CORES-1:0]       buf_ack,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CORE_ID_W-1:0]       out_core_id,
  output logic [VAL_W-1:0]           out_val_1,
  output logic [VAL_W-1:0]           out_val_2,
  output logic                       all_done,
  output logic                       busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = CORE_ID_W + 1;

  arb_state_t           state;
  arb_state_t           state_next;
  logic [NUM_CORES-1:0] collected;
  logic [NUM_CORES-1:0] eligible;
  logic [CORE_ID_W-1:0] rr_ptr;
  logic [CORE_ID_W-1:0] grant_id;
  logic [CORE_ID_W-1:0] sel_id;
  logic [CORE_ID_W-1:0] cand_id;
  logic [IDX_W-1:0]     wide_idx;
  logic                 sel_found;
  logic                 grant;
  logic                 push;
  logic [VAL_W-1:0]     sel_val_1;
  logic [VAL_W-1:0]     sel_val_2;
  logic [VAL_W-1:0]     val_1_q;
  logic [VAL_W-1:0]     val_2_q;

  logic [ENTRY_W-1:0]   fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic                 pop;

  assign eligible = buf_flag & ~collected;

  // Round-robin search: first eligible core at or after rr_ptr, wrapping at
  // NUM_CORES. The candidate index is formed one bit wider so the wrap can be
  // done by a single subtraction.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    wide_idx  = '0;
    cand_id   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      wide_idx = {1'b0, rr_ptr} + IDX_W'(k);
      if (wide_idx >= IDX_W'(NUM_CORES)) begin
        wide_idx = wide_idx - IDX_W'(NUM_CORES);
      end
      cand_id = wide_idx[CORE_ID_W-1:0];
      if (!sel_found && eligible[cand_id]) begin
        sel_found = 1'b1;
        sel_id    = cand_id;
      end
    end
  end

  // Result-word mux for the selected core, using constant part-selects.
  always_comb begin
    sel_val_1 = '0;
    sel_val_2 = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (sel_id == CORE_ID_W'(k)) begin
        sel_val_1 = buf_val_1_flat[k*VAL_W +: VAL_W];
        sel_val_2 = buf_val_2_flat[k*VAL_W +: VAL_W];
      end
    end
  end

  // Full is judged on the registered count, so a pop this cycle only frees a
  // slot for the next scan.
  assign grant = (state == ST_SCAN) && sel_found && !fifo_full;

  // Next state and the capture-cycle strobes. Reset masks the push and ack
  // so a capture interrupted by reset leaves no trace.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    buf_ack    = '0;
    case (state)
      ST_SCAN: begin
        if (grant) begin
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_next = ST_SCAN;
        if (!Reset) begin
          push              = 1'b1;
          buf_ack[grant_id] = 1'b1;
        end
      end
      default: state_next = ST_SCAN;
    endcase
  end

  // Values are latched during the scan cycle, so later changes on the core's
  // outputs cannot disturb the queued entry. clear_epoch is applied after the
  // capture bookkeeping so it wins when both happen together.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_SCAN;
      collected <= '0;
      rr_ptr    <= '0;
      grant_id  <= '0;
      val_1_q   <= '0;
      val_2_q   <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        grant_id <= sel_id;
        val_1_q  <= sel_val_1;
        val_2_q  <= sel_val_2;
      end
      if (state == ST_CAPTURE) begin
        collected[grant_id] <= 1'b1;
        rr_ptr <= (grant_id == CORE_ID_W'(NUM_CORES - 1)) ? '0 : grant_id + 1'b1;
      end
      if (clear_epoch) begin
        collected <= '0;
        rr_ptr    <= '0;
      end
    end
  end

  result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk   (Clk),
    .reset (Reset),
    .push  (push),
    .pop   (pop),
    .din   (pack_entry(grant_id, val_1_q, val_2_q)),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = !Reset && !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign {out_core_id, out_val_1, out_val_2} = out_valid ? fifo_dout : '0;
  assign all_done  = !Reset && (&collected);
  assign busy      = !Reset && ((state == ST_CAPTURE) || (fifo_count != '0));

endmodule

// File: tb/tb_buf_collect_arbiter.sv
// ---------------------------------------------------------------------------
// tb_buf_collect_arbiter
// Scoreboard bench: a transaction-level model predicts which core is acked
// each cycle and which entries must appear on the output; a separate monitor
// pops predicted entries whenever the DUT hands one over.
// ---------------------------------------------------------------------------
module tb_buf_collect_arbiter;

  localparam int NC    = 31;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     buf_flag;
  logic [32*NC-1:0]  buf_val_1_flat;
  logic [32*NC-1:0]  buf_val_2_flat;
  logic              clear_epoch;
  logic [NC-1:0]     buf_ack;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_core_id;
  logic [31:0]       out_val_1;
  logic [31:0]       out_val_2;
  logic              all_done;
  logic              busy;

  always #5 clk = ~clk;

  buf_collect_arbiter #(
    .NUM_CORES  (NC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .Clk            (clk),
    .Reset          (reset),
    .buf_flag       (buf_flag),
    .buf_val_1_flat (buf_val_1_flat),
    .buf_val_2_flat (buf_val_2_flat),
    .clear_epoch    (clear_epoch),
    .buf_ack        (buf_ack),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_core_id    (out_core_id),
    .out_val_1      (out_val_1),
    .out_val_2      (out_val_2),
    .all_done       (all_done),
    .busy           (busy)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Reference model state: which cores are collected this epoch, where the
  // round-robin search resumes, how many results sit in the queue, and the
  // capture (if any) that must happen in the current cycle.
  logic [NC-1:0] m_collected;
  int            m_ptr;
  int            m_count;
  bit            m_cap;
  int            m_cap_id;
  logic [31:0]   m_cap_v1, m_cap_v2;
  logic [68:0]   sb_q[$];
  int            ack_seen[$];
  int            popped;

  logic [NC-1:0] exp_ack, elig;
  bit            nxt_cap, m_pop;
  int            nxt_id, cand;
  logic [31:0]   nxt_v1, nxt_v2;

  always @(negedge clk) begin
    if (reset) begin
      checkOutput("reset_buf_ack", buf_ack, 0);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_all_done", all_done, 0);
      checkOutput("reset_busy", busy, 0);
      m_collected = '0;
      m_ptr       = 0;
      m_count     = 0;
      m_cap       = 1'b0;
      sb_q.delete();
    end else begin
      exp_ack = '0;
      if (m_cap) exp_ack[m_cap_id[4:0]] = 1'b1;
      checkOutput("buf_ack", buf_ack, exp_ack);
      for (int i = 0; i < NC; i++) if (buf_ack[i]) ack_seen.push_back(i);
      checkOutput("out_valid", out_valid, m_count > 0);
      checkOutput("all_done", all_done, &m_collected);
      checkOutput("busy", busy, m_cap || (m_count > 0));
      if (m_count == 0) checkOutput("empty_head", {out_core_id, out_val_1, out_val_2}, 0);

      // A core can be chosen only in a cycle that is not itself a capture,
      // and only while the queue (as it stood at the start of the cycle) has room.
      nxt_cap = 1'b0;
      nxt_id  = 0;
      nxt_v1  = '0;
      nxt_v2  = '0;
      if (!m_cap && m_count < DEPTH) begin
        elig = buf_flag & ~m_collected;
        for (int k = 0; k < NC; k++) begin
          cand = (m_ptr + k) % NC;
          if (!nxt_cap && elig[cand[4:0]]) begin
            nxt_cap = 1'b1;
            nxt_id  = cand;
          end
        end
        if (nxt_cap) begin
          nxt_v1 = 32'(buf_val_1_flat >> (32 * nxt_id));
          nxt_v2 = 32'(buf_val_2_flat >> (32 * nxt_id));
        end
      end

      m_pop = (m_count > 0) && out_ready;
      if (m_cap) begin
        sb_q.push_back({5'(m_cap_id), m_cap_v1, m_cap_v2});
        m_collected[m_cap_id[4:0]] = 1'b1;
        m_ptr = (m_cap_id + 1) % NC;
      end
      if (clear_epoch) begin
        m_collected = '0;
        m_ptr       = 0;
      end
      m_count  = m_count + (m_cap ? 1 : 0) - (m_pop ? 1 : 0);
      m_cap    = nxt_cap;
      m_cap_id = nxt_id;
      m_cap_v1 = nxt_v1;
      m_cap_v2 = nxt_v2;
    end
  end

  // Monitor: whenever the DUT hands over a result, it must be the oldest
  // predicted entry.
  logic [68:0] mon_e;
  always begin
    @(negedge clk);
    #2;
    if (!reset && out_valid && out_ready) begin
      popped++;
      if (sb_q.size() == 0) begin
        checks_total++;
        $display("[TB] FAIL unexpected_output: got id %0d, expected no entry", out_core_id);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("out_core_id", out_core_id, mon_e[68:64]);
        checkOutput("out_val_1", out_val_1, mon_e[63:32]);
        checkOutput("out_val_2", out_val_2, mon_e[31:0]);
      end
    end
  end

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [NC-1:0] flags, input logic ready, input int cycles);
    buf_flag  = flags;
    out_ready = ready;
    stepCycles(cycles);
  endtask

  task automatic setVal(input int core, input logic [31:0] v1, input logic [31:0] v2);
    buf_val_1_flat[32*core +: 32] = v1;
    buf_val_2_flat[32*core +: 32] = v2;
  endtask

  task automatic doReset();
    reset       = 1'b1;
    buf_flag    = '0;
    clear_epoch = 1'b0;
    out_ready   = 1'b0;
    stepCycles(2);
    reset = 1'b0;
    ack_seen.delete();
    popped = 0;
  endtask

  logic [NC-1:0] all_ones;
  logic [NC-1:0] one_bit;

  initial begin
    reset          = 1'b1;
    buf_flag       = '0;
    buf_val_1_flat = '0;
    buf_val_2_flat = '0;
    clear_epoch    = 1'b0;
    out_ready      = 1'b0;
    popped         = 0;
    all_ones       = '1;
    stepCycles(3);

    // Single core 5: ack in the cycle after the flag, entry one cycle later.
    doReset();
    setVal(5, 32'h11, 32'h22);
    one_bit = NC'(1) << 5;
    applyStimulus(one_bit, 1'b1, 1);
    checkOutput("A_ack5", buf_ack, one_bit);
    setVal(5, 32'h33, 32'h44);
    stepCycles(1);
    checkOutput("A_ack_gone", buf_ack, 0);
    checkOutput("A_valid", out_valid, 1);
    checkOutput("A_id", out_core_id, 5);
    checkOutput("A_v1", out_val_1, 32'h11);
    checkOutput("A_v2", out_val_2, 32'h22);
    stepCycles(6);
    checkOutput("A_no_regrant", ack_seen.size(), 1);

    // All flags, parent always ready: ids 0..30 in order, then all_done.
    doReset();
    for (int i = 0; i < NC; i++) setVal(i, $urandom, $urandom);
    applyStimulus(all_ones, 1'b1, 64);
    checkOutput("B_ack_count", ack_seen.size(), NC);
    for (int i = 0; i < NC && i < ack_seen.size(); i++) checkOutput("B_order", ack_seen[i], i);
    checkOutput("B_all_done", all_done, 1);
    checkOutput("B_popped", popped, NC);

    // All flags, parent stalled: exactly four captures, then resume with id 4.
    doReset();
    applyStimulus(all_ones, 1'b0, 20);
    checkOutput("C_ack_count", ack_seen.size(), 4);
    for (int i = 0; i < 4 && i < ack_seen.size(); i++) checkOutput("C_order", ack_seen[i], i);
    checkOutput("C_head_id", out_core_id, 0);
    applyStimulus(all_ones, 1'b1, 4);
    checkOutput("C_resume_count", ack_seen.size(), 5);
    if (ack_seen.size() > 4) checkOutput("C_resume_id", ack_seen[4], 4);
    stepCycles(4);

    // Core 7 held high: captured once, then again after clear_epoch.
    doReset();
    one_bit = NC'(1) << 7;
    applyStimulus(one_bit, 1'b1, 6);
    checkOutput("D_once", ack_seen.size(), 1);
    clear_epoch = 1'b1;
    stepCycles(1);
    clear_epoch = 1'b0;
    stepCycles(6);
    checkOutput("D_twice", ack_seen.size(), 2);
    if (ack_seen.size() == 2) checkOutput("D_second_id", ack_seen[1], 7);

    // Reset during the capture cycle of core 2.
    doReset();
    one_bit = NC'(1) << 2;
    applyStimulus(one_bit, 1'b1, 1);
    reset    = 1'b1;
    buf_flag = '0;
    stepCycles(1);
    reset = 1'b0;
    checkOutput("E_valid", out_valid, 0);
    checkOutput("E_busy", busy, 0);
    checkOutput("E_ack", buf_ack, 0);
    checkOutput("E_id", out_core_id, 0);
    checkOutput("E_v1", out_val_1, 0);
    stepCycles(3);
    checkOutput("E_still_empty", out_valid, 0);
    checkOutput("E_no_ack", ack_seen.size(), 0);

    // Wrap-around: capture 29 so the search resumes at 30, then offer 3 and 30.
    doReset();
    one_bit = NC'(1) << 29;
    applyStimulus(one_bit, 1'b1, 6);
    one_bit = one_bit | (NC'(1) << 30) | (NC'(1) << 3);
    applyStimulus(one_bit, 1'b1, 10);
    checkOutput("F_count", ack_seen.size(), 3);
    if (ack_seen.size() == 3) begin
      checkOutput("F_first", ack_seen[1], 30);
      checkOutput("F_second", ack_seen[2], 3);
    end

    // Randomized traffic with changing values, stalls and epoch clears.
    doReset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < NC; i++) setVal(i, $urandom, $urandom);
      if ($urandom_range(0, 5) == 0) buf_flag = NC'($urandom & $urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      clear_epoch = ($urandom_range(0, 39) == 0);
      stepCycles(1);
    end
    clear_epoch = 1'b0;
    applyStimulus('0, 1'b1, 20);
    checkOutput("G_drained", sb_q.size(), 0);
    checkOutput("G_valid_idle", out_valid, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/buf_collect_arbiter.md
BUF_COLLECT_ARBITER -- requirements
Module: buf_collect_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 31, meaning the number of child cores scanned (1..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of result-queue entries (power of two, >=2).
REQ-003 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port buf_flag  input  NUM_CORES  per-core "result ready" flag.
REQ-006 SHALL have port buf_val_1_flat  input  32*NUM_CORES  core i's first result in bits [32i+31:32i].
REQ-007 SHALL have port buf_val_2_flat  input  32*NUM_CORES  core i's second result, same packing.
REQ-008 SHALL have port clear_epoch  input  1  one-cycle pulse that starts a new collection epoch.
REQ-009 SHALL have port buf_ack  output  NUM_CORES  one-hot, one-cycle pulse to the core whose result was captured.
REQ-010 SHALL have port out_valid  output  1  the result-queue head is valid.
REQ-011 SHALL have port out_ready  input  1  the parent core accepts the head.
REQ-012 SHALL have port out_core_id  output  5  core index of the head entry.
REQ-013 SHALL have port out_val_1 / out_val_2  output  32 each  results of the head entry.
REQ-014 SHALL have port all_done  output  1  every core has been captured in the current epoch.
REQ-015 SHALL have port busy  output  1  the FSM is in CAPTURE or the queue is non-empty.

Function
REQ-016 SHALL implement a two-state FSM, SCAN and CAPTURE.
REQ-017 In SCAN, the eligible set SHALL be buf_flag & ~collected.
REQ-018 In SCAN, the block SHALL select the eligible core at or after rr_ptr, searching upward and wrapping from NUM_CORES-1 to 0.
REQ-019 In SCAN, if a core is selected and the queue is not full, the block SHALL register grant_id, latch that core's two values and enter CAPTURE.
REQ-020 In SCAN, if no core is eligible or the queue is full, the FSM SHALL stay in SCAN with no side effects.
REQ-021 In CAPTURE, the block SHALL push {grant_id, val_1, val_2} into the queue.
REQ-022 In CAPTURE, the block SHALL assert buf_ack[grant_id] for exactly this cycle.
REQ-023 In CAPTURE, the block SHALL set collected[grant_id], set rr_ptr to grant_id+1 (wrapping to 0 after NUM_CORES-1), and return to SCAN.
REQ-024 Latency SHALL be: flag visible at edge N -> buf_ack high during cycle N+1 -> out_valid high from edge N+2 if the queue was empty.
REQ-025 Peak capture rate SHALL be one result per two cycles.
REQ-026 Values SHALL be sampled in the SCAN cycle; later changes in the core's outputs SHALL NOT alter the queued entry.
REQ-027 A queue pop SHALL occur when out_valid && out_ready.
REQ-028 A push and a pop in the same cycle SHALL both take effect, with the count unchanged.
REQ-029 A pop from an empty queue SHALL be ignored.
REQ-030 The queue SHALL be first-in first-out; the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 The full check in SCAN SHALL use the registered count, so a pop in that cycle SHALL NOT enable a grant until the next cycle.
REQ-032 A core whose flag stays high after its ack SHALL NOT be re-granted until clear_epoch.
REQ-033 clear_epoch SHALL zero collected and rr_ptr on the next edge.
REQ-034 If clear_epoch arrives during CAPTURE, the capture SHALL complete (push and ack), and collected SHALL still end all-zero.
REQ-035 all_done SHALL equal &collected[NUM_CORES-1:0], registered.
REQ-036 out_core_id SHALL be zero-extended from the core index.

Reset
REQ-037 Reset SHALL take priority over all other inputs.
REQ-038 On Reset, the FSM SHALL go to SCAN, and collected, rr_ptr, the queue pointers and the count SHALL be zero.
REQ-039 Under Reset, buf_ack=0, out_valid=0, all_done=0 and busy=0; out_core_id, out_val_1 and out_val_2 SHALL read 0 while empty.
REQ-040 Reset asserted mid-CAPTURE SHALL suppress that cycle's push and ack.

Structure
REQ-041 FSM state encodings, the 5-bit core-id width and the entry width (69 bits) SHALL live in the shared multicore header.
REQ-042 The queue SHALL be the one sub-module, result_fifo (parameterised width and depth; push/pop/full/empty/count).
REQ-043 The round-robin search SHALL be combinational inside buf_collect_arbiter.

Verification
REQ-044 The bench SHALL cover: only buf_flag[5] high, vals 0x11/0x22 -> buf_ack[5] pulses one cycle, then out_valid with id 5 and 0x11/0x22.
REQ-045 The bench SHALL cover: all flags high, out_ready=1 -> ids emitted 0,1,...,30 in order, one per 2 cycles, and all_done=1 after the 31st ack.
REQ-046 The bench SHALL cover: all flags high, out_ready=0 -> exactly 4 acks (ids 0-3), then no further ack; raising out_ready resumes with id 4.
REQ-047 The bench SHALL cover: flag[7] held high, one capture, then clear_epoch -> core 7 is captured a second time.
REQ-048 The bench SHALL cover: Reset asserted in the CAPTURE cycle of core 2 -> no buf_ack, queue empty, all outputs 0 next cycle.
REQ-049 The bench SHALL cover: rr_ptr=30 with flags 3 and 30 set -> 30 is granted first, then 3 (wrap-around).
